// File: rtl/common_pkg.sv
// Shared types and constants for the boot-time program loader.
package common_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN,
    DATA,
    CSUM,
    RUN,
    ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, 2-flop input synchroniser, one-cycle rx_valid pulse.
// A byte with a low stop bit is dropped without any indication.
module uart_rx
  import common_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output uart_state_e rx_state
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  uart_state_e   state, next;

  assign rx_state = state;
  assign tick     = (cnt == CW'(CPB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= next;
  end

  // Start bit is re-checked at its midpoint so a glitch does not start a byte.
  always_comb begin
    next = state;
    case (state)
      RX_IDLE:  if (!rx_s) next = RX_START;
      RX_START: if (cnt == CW'(HALF - 1)) next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) next = RX_STOP;
      RX_STOP:  if (tick) next = RX_IDLE;
      default:  next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= (cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (tick) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives SYNC|LEN|words over UART, writes instruction memory, holds the core
// in reset until a full image is loaded. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module program_loader
  import common_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_serial,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_error,
  output logic [15:0]   words_loaded,
  output loader_state_e state,
  output uart_state_e   rx_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_DATA = CSUM;
`else
  localparam loader_state_e AFTER_DATA = RUN;
`endif

  logic [7:0]    rx_data;
  logic          rx_valid;
  loader_state_e next;
  logic [1:0]    byte_cnt;
  logic [23:0]   len_buf, word_buf;
  logic [15:0]   len_words;
  logic [TW-1:0] tcnt;
  logic [31:0]   len_full;
  logic          in_frame, is_sync, last_byte, timeout;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_state (rx_state)
  );

  assign core_rst   = (state != RUN);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERROR);

  assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);
  assign is_sync   = rx_valid && (rx_data == LOADER_SYNC_BYTE);
  assign last_byte = rx_valid && (byte_cnt == 2'd3);
  assign len_full  = {rx_data, len_buf};
  // A byte arriving in the expiring cycle takes precedence over the timeout.
  assign timeout   = in_frame && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      WAIT_SYNC, RUN, ERROR: if (is_sync) next = LEN;
      LEN: begin
        if (last_byte) begin
          if (len_full > 32'(MAX_WORDS)) next = ERROR;
          else if (len_full == 32'd0)    next = AFTER_DATA;
          else                           next = DATA;
        end else if (timeout) begin
          next = ERROR;
        end
      end
      DATA: begin
        if (last_byte) begin
          if (words_loaded + 16'd1 == len_words) next = AFTER_DATA;
        end else if (timeout) begin
          next = ERROR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (rx_valid)     next = (rx_data == csum) ? RUN : ERROR;
        else if (timeout) next = ERROR;
      end
`endif
      default: next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      len_buf      <= '0;
      word_buf     <= '0;
      len_words    <= '0;
      tcnt         <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      tcnt    <= (in_frame && !rx_valid) ? tcnt + 1'b1 : '0;
      case (state)
        WAIT_SYNC, RUN, ERROR: begin
          if (is_sync) begin
            byte_cnt     <= '0;
            words_loaded <= '0;
            len_buf      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        LEN: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) len_words <= len_full[15:0];
            else                  len_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
          end
        end
        DATA: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= {14'd0, words_loaded, 2'b00};
              imem_wdata   <= {rx_data, word_buf};
              words_loaded <= words_loaded + 16'd1;
            end else begin
              word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; an imem write monitor drains an expected-write queue.
// Exercises the checksum scenarios when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  import common_pkg::*;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int MAXW     = 1024;
  localparam int TMO      = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic          imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic          core_rst, load_done, load_error;
  logic [15:0]   words_loaded;
  loader_state_e state;
  uart_state_e   rx_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] fw[0:7];

  program_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded), .state(state), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected (addr, data) pair.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, want no write", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL imem_write: got addr=%h data=%h, want addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Sends SYNC, LEN and nwords words from fw; checksum byte (xor-ed with csum_flip) when enabled.
  task automatic send_frame(input logic [31:0] len_field, input int nwords, input logic [7:0] csum_flip);
    logic [7:0] x;
    x = 8'h00;
    send_byte(LOADER_SYNC_BYTE);
    send_word32(len_field);
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back({32'(i * 4), fw[i]});
      send_word32(fw[i]);
      x = x ^ fw[i][7:0] ^ fw[i][15:8] ^ fw[i][23:16] ^ fw[i][31:24];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ csum_flip);
`else
    if (csum_flip != 8'h00) x = 8'h00;
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    checks++; if (imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_imem_bus: got %h/%h want 0/0", imem_addr, imem_wdata); end
    checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b want 0/0", load_done, load_error); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    checks++; if (state !== WAIT_SYNC) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, WAIT_SYNC); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_load();
    fw[0] = 32'h0010_0013;
    fw[1] = 32'h0020_0093;
    send_frame(32'd2, 2, 8'h00);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_writes_left: got %0d want 0", exp_q.size()); end
    checks++; if (core_rst !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL basic_run: got core_rst=%b done=%b want 0/1", core_rst, load_done); end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
  endtask

  task automatic test_noise_before_sync();
    apply_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++; if (state !== WAIT_SYNC || core_rst !== 1'b1) begin errors++; $display("FAIL noise_ignored: got state=%0d core_rst=%b want %0d/1", state, core_rst, WAIT_SYNC); end
    fw[0] = $urandom;
    send_frame(32'd1, 1, 8'h00);
    checks++; if (load_done !== 1'b1 || words_loaded !== 16'd1) begin errors++; $display("FAIL noise_load: got done=%b words=%0d want 1/1", load_done, words_loaded); end
  endtask

  task automatic test_len_overflow();
    send_frame(32'(MAXW + 1), 0, 8'h00);
    checks++; if (load_error !== 1'b1 || core_rst !== 1'b1 || state !== ERROR) begin errors++; $display("FAIL overflow_error: got err=%b core_rst=%b state=%0d want 1/1/%0d", load_error, core_rst, state, ERROR); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL overflow_words: got %0d want 0", words_loaded); end
    fw[0] = 32'hCAFE_F00D;
    send_frame(32'd1, 1, 8'h00);
    checks++; if (load_error !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL overflow_recover: got err=%b done=%b want 0/1", load_error, load_done); end
    fw[0] = 32'hA5A5_0001;
    send_frame(32'(MAXW), 1, 8'h00);
    checks++; if (state !== DATA) begin errors++; $display("FAIL max_len_accept: got state=%0d want %0d", state, DATA); end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_byte(LOADER_SYNC_BYTE);
    send_word32(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO - 100) @(negedge clk);
    checks++; if (state !== DATA) begin errors++; $display("FAIL timeout_early: got state=%0d want %0d", state, DATA); end
    repeat (200) @(negedge clk);
    checks++; if (state !== ERROR || load_error !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL timeout_error: got state=%0d err=%b core_rst=%b want %0d/1/1", state, load_error, core_rst, ERROR); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL timeout_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_reload_from_run();
    fw[0] = 32'h1111_2222;
    fw[1] = 32'h3333_4444;
    send_frame(32'd2, 2, 8'h00);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL reload_pre_run: got core_rst=%b want 0", core_rst); end
    send_byte(LOADER_SYNC_BYTE);
    checks++; if (core_rst !== 1'b1 || load_done !== 1'b0 || state !== LEN) begin errors++; $display("FAIL reload_sync: got core_rst=%b done=%b state=%0d want 1/0/%0d", core_rst, load_done, state, LEN); end
    fw[0] = 32'hDEAD_BEEF;
    exp_q.push_back({32'd0, fw[0]});
    send_word32(32'd1);
    send_word32(fw[0]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(fw[0][7:0] ^ fw[0][15:8] ^ fw[0][23:16] ^ fw[0][31:24]);
`endif
    repeat (4) @(negedge clk);
    checks++; if (load_done !== 1'b1 || words_loaded !== 16'd1 || exp_q.size() != 0) begin errors++; $display("FAIL reload_done: got done=%b words=%0d pending=%0d want 1/1/0", load_done, words_loaded, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) fw[i] = $urandom;
    fw[2] = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send_frame(32'd6, 6, 8'h00);
    checks++; if (words_loaded !== 16'd6 || load_done !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL b2b: got words=%0d done=%b pending=%0d want 6/1/0", words_loaded, load_done, exp_q.size()); end
  endtask

  task automatic test_len_zero();
    send_frame(32'd0, 0, 8'h00);
    checks++; if (load_done !== 1'b1 || words_loaded !== 16'd0) begin errors++; $display("FAIL len_zero: got done=%b words=%0d want 1/0", load_done, words_loaded); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    fw[0] = 32'h0010_0013;
    send_frame(32'd1, 1, 8'h00);
    checks++; if (state !== RUN) begin errors++; $display("FAIL csum_good: got state=%0d want %0d", state, RUN); end
    send_frame(32'd1, 1, 8'h07);
    checks++; if (state !== ERROR || load_error !== 1'b1) begin errors++; $display("FAIL csum_bad: got state=%0d err=%b want %0d/1", state, load_error, ERROR); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_noise_before_sync();
    test_len_overflow();
    test_timeout();
    test_reload_from_run();
    test_back_to_back();
    test_len_zero();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
